// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads over req/ack, buffers {pc, instr}
// in a small FIFO and presents the head to decode; redirects flush everything.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] opcode,
    output logic [31:0] pc_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // state | meaning
    // IDLE  | no request outstanding (FIFO full or just redirected)
    // REQ   | live request on imem, result will be pushed
    // DROP  | request outstanding but made stale by a redirect; result discarded
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   addr, addr_next;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   fifo_pc  [DEPTH];
    logic [31:0]   fifo_ins [DEPTH];
    logic          push, pop, room;
    logic [31:0]   redirect_target;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign instr_valid     = (count != '0);
    assign pop             = instr_valid & instr_ready;
    assign push            = (state == REQ) & imem_ack & ~redirect_valid;
    assign count_next      = count + CW'(push) - CW'(pop);
    assign room            = (count_next < CW'(DEPTH));
    assign imem_addr       = addr;
    assign opcode          = instr_valid ? fifo_ins[rd_ptr] : NOP;
    assign pc_out          = instr_valid ? fifo_pc[rd_ptr] : 32'h0;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = addr;
        imem_req      = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_target;
                end else if (room) begin
                    state_next = REQ;
                    addr_next  = fetch_pc;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    fetch_pc_next = redirect_target;
                    state_next    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    if (room) addr_next = fetch_pc + 32'd4;
                    else      state_next = IDLE;
                end
            end
            DROP: begin
                imem_req = 1'b1;
                if (redirect_valid) fetch_pc_next = redirect_target;
                // the stale request completes here even if another redirect lands
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr     <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            addr     <= addr_next;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_next;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]  <= addr;
            fifo_ins[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, full FIFO, slow ack, redirects, wrap, reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] opcode;
    logic [31:0] pc_out;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .opcode(opcode), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b0;
        #2;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
            opcode !== 32'h13 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset: req=%b addr=%h valid=%b op=%h pc=%h need 0/0/0/00000013/0",
                     imem_req, imem_addr, instr_valid, opcode, pc_out);
        end
    endtask

    task automatic test_stream();
        imem_ack = 1'b1; instr_ready = 1'b1;
        do_reset();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL stream_start: valid=%b req=%b addr=%h need 0/1/0", instr_valid, imem_req, imem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(4*i) || opcode !== mem_word(32'(4*i))) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h op=%h need 1/%h/%h",
                         i, instr_valid, pc_out, opcode, 32'(4*i), mem_word(32'(4*i)));
            end
        end
    endtask

    task automatic test_full();
        imem_ack = 1'b1; instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL full_hold: valid=%b req=%b pc=%h need 1/0/0", instr_valid, imem_req, pc_out);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(4*i) || opcode !== mem_word(32'(4*i))) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b pc=%h op=%h need 1/%h/%h",
                         i, instr_valid, pc_out, opcode, 32'(4*i), mem_word(32'(4*i)));
            end
            tick();
            if (i == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL resume: req=%b addr=%h need 1/00000010", imem_req, imem_addr);
                end
            end
        end
    endtask

    task automatic test_delay();
        imem_ack = 1'b0; instr_ready = 1'b1;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL delay_hold[%0d]: req=%b addr=%h valid=%b need 1/0/0",
                         i, imem_req, imem_addr, instr_valid);
            end
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h0 || opcode !== mem_word(32'h0) ||
            imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL delay_ack: valid=%b pc=%h op=%h req=%b addr=%h need 1/0/%h/1/4",
                     instr_valid, pc_out, opcode, imem_req, imem_addr, mem_word(32'h0));
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL delay_single_push: valid=%b need 0", instr_valid);
        end
    endtask

    // continues from test_delay: REQ pending at 0x4, ack low
    task automatic test_redirect_drop();
        redirect_valid = 1'b1; redirect_pc = 32'h1003;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold: req=%b addr=%h valid=%b need 1/4/0", imem_req, imem_addr, instr_valid);
        end
        imem_ack = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_discard: req=%b valid=%b need 0/0", imem_req, instr_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL drop_target: req=%b addr=%h need 1/00001000", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h1000 || opcode !== mem_word(32'h1000)) begin
            errors++;
            $display("FAIL drop_first: valid=%b pc=%h op=%h need 1/00001000/%h",
                     instr_valid, pc_out, opcode, mem_word(32'h1000));
        end
    endtask

    // streaming with ack and ready high: redirect collides with push and pop
    task automatic test_same_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h2000;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_out !== 32'h0 || opcode !== 32'h13) begin
            errors++;
            $display("FAIL same_flush: valid=%b req=%b pc=%h op=%h need 0/0/0/00000013",
                     instr_valid, imem_req, pc_out, opcode);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_target: req=%b addr=%h valid=%b need 1/00002000/0",
                     imem_req, imem_addr, instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h2000) begin
            errors++;
            $display("FAIL same_first: valid=%b pc=%h need 1/00002000", instr_valid, pc_out);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc_out !== exp_pc[i] || opcode !== mem_word(exp_pc[i])) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h op=%h need 1/%h/%h",
                         i, instr_valid, pc_out, opcode, exp_pc[i], mem_word(exp_pc[i]));
            end
        end
    endtask

    task automatic test_rst_mid();
        imem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
            opcode !== 32'h13 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: req=%b addr=%h valid=%b op=%h pc=%h need 0/0/0/00000013/0",
                     imem_req, imem_addr, instr_valid, opcode, pc_out);
        end
        tick();
        rst = 1'b0;
        imem_ack = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h0 || opcode !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL rst_restart: valid=%b pc=%h op=%h need 1/0/%h",
                     instr_valid, pc_out, opcode, mem_word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_delay();
        test_redirect_drop();
        test_same_cycle();
        test_wrap();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that produces the 32-bit `opcode` word consumed by the decode stage, paired with its PC.
- Issues word reads to instruction memory over a req/ack handshake and buffers returned words in a small FIFO.
- Presents the FIFO head to decode with valid/ready flow control.
- Handles PC redirects from branch/jump resolution, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, PC of the first fetch after reset.
- DEPTH, 4, instruction FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  32  word address of current request; stable while imem_req=1; bits [1:0] always 0.
- imem_ack  in  1  read complete; sampled only while imem_req=1; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0).
- instr_ready  in  1  decode accepts head this cycle.
- instr_valid  out  1  FIFO non-empty.
- opcode  out  32  head instruction; 32'h00000013 (addi x0,x0,0) when empty.
- pc_out  out  32  PC of head instruction; 0 when empty.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC, FIFO empty, state IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, opcode=32'h13, pc_out=0.
- Registers: fetch_pc (next address to request), FIFO of {pc,instr}, count 0..DEPTH, FSM {IDLE, REQ, DROP}.
- pop = instr_valid & instr_ready. push = REQ & imem_ack & ~redirect_valid.
- count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- IDLE:
  - imem_req=0.
  - If ~redirect_valid and count_next<DEPTH: go to REQ, imem_addr←fetch_pc.
- REQ:
  - imem_req=1.
  - On ack without redirect: push {imem_addr, imem_rdata}, fetch_pc←fetch_pc+4.
  - After the ack, if count_next<DEPTH: stay in REQ with imem_addr←fetch_pc+4 (back-to-back, 1 instr/cycle when ack is same-cycle). Otherwise go to IDLE.
  - No ack: hold imem_addr and stay.
- DROP:
  - imem_req=1, imem_addr held (stale request).
  - On imem_ack: discard rdata and go to IDLE.
- Redirect (highest priority, over push and pop in the same cycle):
  - FIFO flushed (count←0), fetch_pc←{redirect_pc[31:2],2'b00}.
  - From IDLE: stay IDLE.
  - From REQ with imem_ack the same cycle: data discarded, go to IDLE.
  - From REQ without ack: go to DROP.
  - From DROP: stay DROP, fetch_pc updated.
  - instr_valid=0 the cycle after a redirect.
- Full FIFO: no request issued (IDLE). Reaching full also accounts for the word pushed on that ack.
- PC arithmetic: 32-bit, wraps (32'hFFFFFFFC+4=0).
- At most one outstanding request. imem_addr never changes while imem_req=1 and no ack.
- Latency: with same-cycle ack, first instr_valid=1 on the 2nd rising edge after rst deasserts. Steady state is 1 instruction/cycle.
- Outputs opcode/pc_out/instr_valid are driven from FIFO head state (no combinational path from imem_rdata).

Test Plan:
- Reset release, imem_ack tied high, memory returns addr-derived words, instr_ready=1 → opcode stream for pc_out 0x0,0x4,0x8,… one per cycle after 2-cycle startup.
- instr_ready=0, ack high → exactly DEPTH=4 words buffered (pc 0x0–0xC), imem_req drops to 0. Raise ready → drains in order, fetching resumes at 0x10.
- ack delayed 3 cycles → imem_req/imem_addr stable all 3 cycles; single push on ack.
- redirect_valid with redirect_pc=0x1003 while REQ pending, no ack → DROP. Stale ack data never appears; next request and next pc_out are 0x1000; FIFO flushed.
- Redirect in same cycle as ack and pop → nothing pushed, count=0, instr_valid=0 next cycle, next imem_addr=redirect target.
- Redirect to 0xFFFFFFF8, ready=1 → pc_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert rst mid-REQ → outputs return to reset values immediately; fetch restarts at RESET_PC.
